// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the unified main-memory arbiter.
// Holds the FSM state encoding, the grant encoding and default sizes.
package memory_arbiter_pkg;

  localparam int BLOCK_WORDS_DEF = 8;
  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of cache-miss request, memory port and fill-return signals.
// slave = arbiter side, master = caches plus main memory.
interface memory_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              IRequest;
  logic [ADDR_W-1:0] IAddress;
  logic              DRequest;
  logic [ADDR_W-1:0] DAddress;
  logic              DWriteEnable;
  logic [DATA_W-1:0] DWriteData;
  logic [DATA_W-1:0] MemReadData;
  logic              MemDataValid;
  logic [ADDR_W-1:0] MemAddress;
  logic              MemEnable;
  logic              MemWrite;
  logic [DATA_W-1:0] MemWriteData;
  logic [DATA_W-1:0] IMemData;
  logic [DATA_W-1:0] DMemData;
  logic              IMemDataValid;
  logic              DMemDataValid;
  logic [ADDR_W-1:0] IFillAddress;
  logic [ADDR_W-1:0] DFillAddress;
  logic              IStall;
  logic              DStall;

  modport slave (
    input  IRequest, IAddress, DRequest, DAddress, DWriteEnable, DWriteData,
           MemReadData, MemDataValid,
    output MemAddress, MemEnable, MemWrite, MemWriteData,
           IMemData, DMemData, IMemDataValid, DMemDataValid,
           IFillAddress, DFillAddress, IStall, DStall
  );

  modport master (
    output IRequest, IAddress, DRequest, DAddress, DWriteEnable, DWriteData,
           MemReadData, MemDataValid,
    input  MemAddress, MemEnable, MemWrite, MemWriteData,
           IMemData, DMemData, IMemDataValid, DMemDataValid,
           IFillAddress, DFillAddress, IStall, DStall
  );
endinterface

// File: rtl/memory_arbiter_block_fill_sequencer.sv
// Block-fill address sequencer: aligned base, issue/return counters and
// last-return detect. Offsets never carry out of the block.
module block_fill_sequencer #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_fill,
  input  logic              i_ret_vld,
  output logic              o_issue_vld,
  output logic [ADDR_W-1:0] o_issue_addr,
  output logic [ADDR_W-1:0] o_ret_addr,
  output logic              o_last_ret
);
  localparam int                CNT_W    = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(BLOCK_WORDS - 1);

  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_ret_cnt;
  logic              r_issue_done;

  assign o_issue_vld  = i_fill & ~r_issue_done;
  assign o_issue_addr = r_base + (ADDR_W'(r_issue_cnt) << 1);
  assign o_ret_addr   = r_base + (ADDR_W'(r_ret_cnt) << 1);
  assign o_last_ret   = i_ret_vld & (r_ret_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base       <= '0;
      r_issue_cnt  <= '0;
      r_ret_cnt    <= '0;
      r_issue_done <= 1'b0;
    end else if (i_start) begin
      r_base       <= i_addr & ~OFF_MASK;
      r_issue_cnt  <= '0;
      r_ret_cnt    <= '0;
      r_issue_done <= 1'b0;
    end else begin
      // issue side stops after the last word; returns keep counting
      if (o_issue_vld) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
        if (r_issue_cnt == LAST) r_issue_done <= 1'b1;
      end
      if (i_ret_vld) r_ret_cnt <= r_ret_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Unified main-memory arbiter between I-cache and D-cache misses.
// D has fixed priority; grants run to completion and end in a one-cycle DONE.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  memory_arbiter_if.slave  bus
);
  state_t            r_state, w_state_nxt;
  grant_t            r_grant, w_grant_nxt;
  logic              w_start;
  logic              w_latch_wr;
  logic [ADDR_W-1:0] w_req_addr;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_fill;
  logic              w_write;
  logic              w_done;
  logic              w_ret_vld;
  logic              w_issue_vld;
  logic              w_last_ret;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [ADDR_W-1:0] w_ret_addr;
  logic              w_i_vld;
  logic              w_d_vld;

  assign w_fill     = (r_state == ST_FILL);
  assign w_write    = (r_state == ST_WRITE);
  assign w_done     = (r_state == ST_DONE);
  // returns outside FILL belong to reads issued before a reset
  assign w_ret_vld  = bus.MemDataValid & w_fill;
  assign w_req_addr = bus.DRequest ? bus.DAddress : bus.IAddress;

  block_fill_sequencer #(
    .BLOCK_WORDS(BLOCK_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst),
    .i_start     (w_start),
    .i_addr      (w_req_addr),
    .i_fill      (w_fill),
    .i_ret_vld   (w_ret_vld),
    .o_issue_vld (w_issue_vld),
    .o_issue_addr(w_issue_addr),
    .o_ret_addr  (w_ret_addr),
    .o_last_ret  (w_last_ret)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_grant <= GRANT_I;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_latch_wr) begin
      r_waddr <= bus.DAddress;
      r_wdata <= bus.DWriteData;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_start     = 1'b0;
    w_latch_wr  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.DRequest) begin
          w_grant_nxt = GRANT_D;
          w_start     = 1'b1;
          if (bus.DWriteEnable) begin
            w_latch_wr  = 1'b1;
            w_state_nxt = ST_WRITE;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end else if (bus.IRequest) begin
          w_grant_nxt = GRANT_I;
          w_start     = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL:  if (w_last_ret) w_state_nxt = ST_DONE;
      ST_WRITE: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_i_vld = w_ret_vld & (r_grant == GRANT_I);
  assign w_d_vld = w_ret_vld & (r_grant == GRANT_D);

  assign bus.MemEnable    = w_issue_vld | w_write;
  assign bus.MemWrite     = w_write;
  assign bus.MemAddress   = w_issue_vld ? w_issue_addr : (w_write ? r_waddr : '0);
  assign bus.MemWriteData = w_write ? r_wdata : '0;

  assign bus.IMemDataValid = w_i_vld;
  assign bus.DMemDataValid = w_d_vld;
  assign bus.IMemData      = w_i_vld ? bus.MemReadData : '0;
  assign bus.DMemData      = w_d_vld ? bus.MemReadData : '0;
  assign bus.IFillAddress  = w_i_vld ? w_ret_addr : '0;
  assign bus.DFillAddress  = w_d_vld ? w_ret_addr : '0;

  // stalls are forced low while reset is held so every output reads 0
  assign bus.IStall = rst & bus.IRequest & ~(w_done & (r_grant == GRANT_I));
  assign bus.DStall = rst & bus.DRequest & ~(w_done & (r_grant == GRANT_D));

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed requests push expected memory
// accesses and fill returns; a negedge monitor pops and compares them.
module tb_memory_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_arbiter_if bus ();

  memory_arbiter dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t0 = 0;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t mem_q[$];
  ev_t i_q[$];
  ev_t d_q[$];
  ev_t e_m, e_i, e_d;

  // main memory: 4-cycle pipelined read, data = address ^ 0xA5A5
  logic [3:0]  p_vld = '0;
  logic [15:0] p_addr[4];
  always @(posedge clk) begin
    p_vld     <= {p_vld[2:0], bus.MemEnable & ~bus.MemWrite};
    p_addr[0] <= bus.MemAddress;
    for (int i = 1; i < 4; i++) p_addr[i] <= p_addr[i-1];
  end
  assign bus.MemDataValid = p_vld[3];
  assign bus.MemReadData  = p_vld[3] ? (p_addr[3] ^ 16'hA5A5) : 16'h0000;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: output present with nothing expected (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [63:0] pk(input int c, input logic w, input logic [15:0] a,
                                     input logic [15:0] d);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, 15'd0, w, a, d};
  endfunction

  function automatic ev_t ev(input int c, input logic w, input logic [15:0] a,
                             input logic [15:0] d);
    ev_t e;
    e.cyc = c; e.wr = w; e.addr = a; e.data = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs",
            {10'd0, bus.MemEnable, bus.MemWrite, bus.IMemDataValid, bus.DMemDataValid,
             bus.IStall, bus.DStall, bus.MemAddress, bus.IFillAddress, bus.DFillAddress},
            64'd0);
    end else begin
      if (bus.MemEnable) begin
        if (mem_q.size() == 0) unexpected("mem_access");
        else begin
          e_m = mem_q.pop_front();
          check("mem_access", pk(cyc, bus.MemWrite, bus.MemAddress, bus.MemWriteData),
                pk(e_m.cyc, e_m.wr, e_m.addr, e_m.data));
        end
      end
      if (bus.IMemDataValid) begin
        if (i_q.size() == 0) unexpected("i_return");
        else begin
          e_i = i_q.pop_front();
          check("i_return", pk(cyc, 1'b0, bus.IFillAddress, bus.IMemData),
                pk(e_i.cyc, 1'b0, e_i.addr, e_i.data));
        end
      end
      if (bus.DMemDataValid) begin
        if (d_q.size() == 0) unexpected("d_return");
        else begin
          e_d = d_q.pop_front();
          check("d_return", pk(cyc, 1'b0, bus.DFillAddress, bus.DMemData),
                pk(e_d.cyc, 1'b0, e_d.addr, e_d.data));
        end
      end
    end
  end

  task automatic start();
    @(posedge clk); #1;
    t0 = cyc;
  endtask

  task automatic step_to(input int k);
    while (cyc < t0 + k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic neg_at(input int k);
    do @(negedge clk); while (cyc < t0 + k);
  endtask

  task automatic push_fill(input bit is_d, input logic [15:0] base, input int k0);
    logic [15:0] a;
    for (int w = 0; w < 8; w++) begin
      a = base + 16'(2 * w);
      mem_q.push_back(ev(t0 + k0 + 1 + w, 1'b0, a, 16'h0000));
      if (is_d) d_q.push_back(ev(t0 + k0 + 5 + w, 1'b0, a, a ^ 16'hA5A5));
      else      i_q.push_back(ev(t0 + k0 + 5 + w, 1'b0, a, a ^ 16'hA5A5));
    end
  endtask

  task automatic run_i_fill(input string nm, input logic [15:0] addr, input logic [15:0] base);
    start();
    bus.IRequest = 1'b1;
    bus.IAddress = addr;
    push_fill(1'b0, base, 0);
    for (int k = 0; k <= 13; k++) begin
      neg_at(k);
      check(nm, {63'd0, bus.IStall}, {63'd0, (k != 13)});
      if (k == 13) bus.IRequest = 1'b0;
    end
    step_to(15);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.IRequest = 1'b0; bus.IAddress = '0;
    bus.DRequest = 1'b0; bus.DAddress = '0;
    bus.DWriteEnable = 1'b0; bus.DWriteData = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_i_fill("istall_ifill", 16'h0046, 16'h0040);

    // simultaneous: D read first, I waits and starts issuing at cycle 15
    start();
    bus.IRequest = 1'b1; bus.IAddress = 16'h0200;
    bus.DRequest = 1'b1; bus.DAddress = 16'h0310; bus.DWriteEnable = 1'b0;
    push_fill(1'b1, 16'h0310, 0);
    push_fill(1'b0, 16'h0200, 14);
    for (int k = 0; k <= 27; k++) begin
      neg_at(k);
      check("istall_simul", {63'd0, bus.IStall}, {63'd0, (k != 27)});
      if (k <= 13) check("dstall_simul", {63'd0, bus.DStall}, {63'd0, (k != 13)});
      if (k == 13) bus.DRequest = 1'b0;
      if (k == 27) bus.IRequest = 1'b0;
    end
    step_to(29);

    // D write-through
    start();
    bus.DRequest = 1'b1; bus.DAddress = 16'h0100;
    bus.DWriteData = 16'h1234; bus.DWriteEnable = 1'b1;
    mem_q.push_back(ev(t0 + 1, 1'b1, 16'h0100, 16'h1234));
    for (int k = 0; k <= 2; k++) begin
      neg_at(k);
      check("dstall_write", {63'd0, bus.DStall}, {63'd0, (k != 2)});
    end
    bus.DRequest = 1'b0; bus.DWriteEnable = 1'b0;
    step_to(4);

    // I request dropped at cycle 3; fill completes, DONE at 13, D write at 15
    start();
    bus.IRequest = 1'b1; bus.IAddress = 16'h0A08;
    push_fill(1'b0, 16'h0A00, 0);
    neg_at(2);
    check("istall_drop_before", {63'd0, bus.IStall}, 64'd1);
    step_to(3);
    bus.IRequest = 1'b0;
    neg_at(3);
    check("istall_drop_after", {63'd0, bus.IStall}, 64'd0);
    step_to(10);
    bus.DRequest = 1'b1; bus.DAddress = 16'h0B06;
    bus.DWriteData = 16'hBEEF; bus.DWriteEnable = 1'b1;
    mem_q.push_back(ev(t0 + 15, 1'b1, 16'h0B06, 16'hBEEF));
    for (int k = 10; k <= 16; k++) begin
      neg_at(k);
      check("dstall_after_drop", {63'd0, bus.DStall}, {63'd0, (k != 16)});
    end
    bus.DRequest = 1'b0; bus.DWriteEnable = 1'b0;
    step_to(18);

    // reset at cycle 6 of a fill: issues 1..5 and the cycle-5 return only
    start();
    bus.IRequest = 1'b1; bus.IAddress = 16'h1234;
    for (int w = 0; w < 5; w++)
      mem_q.push_back(ev(t0 + 1 + w, 1'b0, 16'h1230 + 16'(2 * w), 16'h0000));
    i_q.push_back(ev(t0 + 5, 1'b0, 16'h1230, 16'h1230 ^ 16'hA5A5));
    step_to(6);
    rst_n = 1'b0;
    bus.IRequest = 1'b0;
    step_to(8);
    rst_n = 1'b1;
    step_to(12);
    run_i_fill("istall_after_reset", 16'h2018, 16'h2010);

    run_i_fill("istall_top", 16'hFFFA, 16'hFFF0);

    for (int n = 0; n < 50 && (mem_q.size() + i_q.size() + d_q.size()) != 0; n++)
      @(posedge clk);
    repeat (6) @(posedge clk);
    check("queues_drained", 64'(mem_q.size() + i_q.size() + d_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sits directly upstream of the instruction fetch stage and the memory stage.
- Owns the single unified main-memory port and arbitrates between the instruction-cache and data-cache miss requests.
- For a read miss, it sequences a block fill of BLOCK_WORDS words and returns each word with a valid pulse and its address.
- Drives the per-requester stall that the fetch and memory stages use to freeze the PC and the pipeline.

Parameters:
- BLOCK_WORDS, 8: 16-bit words per cache block (block = 2*BLOCK_WORDS bytes).
- ADDR_W, 16: address width in bytes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- IRequest  in  1  I-cache miss request; held high until its stall drops.
- IAddress  in  16  I-cache miss byte address.
- DRequest  in  1  D-cache request (read miss or write-through).
- DAddress  in  16  D-cache byte address.
- DWriteEnable  in  1  1 = write-through, 0 = read miss.
- DWriteData  in  16  write data.
- MemReadData  in  16  memory read data.
- MemDataValid  in  1  memory read data valid; fixed pipelined latency of 4 cycles.
- MemAddress  out  16  memory address.
- MemEnable  out  1  memory access strobe.
- MemWrite  out  1  memory write strobe.
- MemWriteData  out  16  memory write data.
- IMemData / DMemData  out  16  returned fill word.
- IMemDataValid / DMemDataValid  out  1  fill word valid.
- IFillAddress / DFillAddress  out  16  byte address of the returned word.
- IStall / DStall  out  1  stall to the requester.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; grant, issue and return counters = 0.
  - All outputs 0.
  - Any MemDataValid arriving while IDLE is ignored. This discards reads still in flight from before reset.
- States:
  - IDLE: accepts a new request.
  - FILL: issues and collects block reads.
  - WRITE: performs one memory write.
  - DONE: one-cycle completion; no new request is accepted.
- IDLE transitions:
  - If DRequest: latch grant=D and the address, then go to WRITE if DWriteEnable, else FILL.
  - Else if IRequest: latch grant=I and go to FILL.
  - D has fixed priority. A granted access is never preempted.
- Fill base address is the request address & ~(2*BLOCK_WORDS-1). For a 16-byte block that is addr & 16'hFFF0.
- FILL, issue side:
  - One read per cycle, for BLOCK_WORDS cycles.
  - MemEnable=1, MemWrite=0, MemAddress = base + 2*issue_cnt.
- FILL, return side:
  - Each MemDataValid forwards MemReadData to the granted side's MemData.
  - That side's MemDataValid is pulsed and its FillAddress = base + 2*return_cnt. The same signals on the other side stay 0.
  - After the BLOCK_WORDS-th valid, go to DONE.
  - Addresses stay inside the block: the top word is base+2*(BLOCK_WORDS-1), with no wrap past the block or past 16'hFFFE.
- Fill timing, with request first seen in IDLE at cycle 0:
  - Issues occur in cycles 1..8.
  - Valids arrive in cycles 5..12.
  - DONE is cycle 13.
  - IDLE is cycle 14, the earliest point a new grant can be taken.
- WRITE: for one cycle, MemEnable=1, MemWrite=1, MemAddress=DAddress, MemWriteData=DWriteData. Next state is DONE.
- Stall rule: XStall = XRequest & ~(state==DONE & grant==X).
  - The requester sees stall low exactly in the DONE cycle of its own access.
  - A requester that is waiting without a grant stays stalled.
- Request dropped mid-FILL (fetch-stage PC disrupt): the fill still runs to completion and all valids are still delivered. The cache may install or discard them.
- Request dropped before grant: no access is started.
- When inactive, MemAddress, MemEnable and MemWrite are 0.
- Arithmetic: 16-bit; issue and return counters are $clog2(BLOCK_WORDS) bits wide.

Decomposition:
- Shared include file holds the state encodings (IDLE/FILL/WRITE/DONE), the GRANT_I/GRANT_D constants and the BLOCK_WORDS default.
- One sub-module, block_fill_sequencer, holds the base register, both counters, address generation and the last-word detect.
- The arbiter FSM and the output muxing stay in memory_arbiter.

Test Plan:
- I-fill:
  - Stimulus: IRequest with IAddress=0x0046 at cycle 0.
  - Response: MemAddress 0x0040..0x004E in cycles 1-8; 8 IMemDataValid pulses in cycles 5-12 with IFillAddress 0x0040..0x004E; IStall high cycles 0-12 and low at cycle 13.
- Simultaneous requests:
  - Stimulus: IRequest (0x0200) and a DRequest read (0x0310) in the same cycle.
  - Response: D block 0x0310-0x031E is served first with IStall held high; I fill issues 0x0200 starting at cycle 15; no I valids appear during the D fill.
- D write:
  - Stimulus: DAddress=0x0100, DWriteData=0x1234, DWriteEnable=1.
  - Response: cycle 1 has MemEnable=MemWrite=1, MemAddress=0x0100, MemWriteData=0x1234; DStall low at cycle 2.
- Request dropped mid-fill:
  - Stimulus: IRequest deasserted at cycle 3 of a fill.
  - Response: issues continue to cycle 8; all 8 IMemDataValid pulses are delivered; DONE at cycle 13.
- Reset mid-fill:
  - Stimulus: rst low at cycle 6.
  - Response: all outputs 0 immediately; the remaining MemDataValid pulses produce no *MemDataValid; a request after release is served from a fresh base.
- Top-of-memory block:
  - Stimulus: IAddress=0xFFFA.
  - Response: issues 0xFFF0..0xFFFE; no address 0x0000 is issued.
